// File: rtl/pulse_width_monitor.sv
// -----------------------------------------------------------------------------
// pulse_width_monitor
//
// Self-checking sink for a pulse train. pulse_in is synchronised into clk, then
// every high and low phase is measured in clk cycles. Each full period
// (low phase followed by high phase) is reported at the falling edge that ends
// the high phase, and both widths are checked against EXP_x +/- TOL.
//
// Ports
//   clk          in   sampling clock
//   reset_n      in   synchronous, active-low reset
//   enable       in   1 = monitor runs; 0 = back to IDLE, results held
//   pulse_in     in   asynchronous pulse train
//   high_width   out  last completed high-phase width (CNT_W)
//   low_width    out  last completed low-phase width (CNT_W)
//   width_valid  out  1-cycle strobe when high_width/low_width update
//   err_high     out  sticky: a high phase fell outside EXP_HIGH +/- TOL
//   err_low      out  sticky: a low phase fell outside EXP_LOW +/- TOL
//   period_cnt   out  completed periods since reset, saturating (CNT_W)
//   locked       out  1 while measuring (LOW or HIGH state)
//   stuck        out  only with PULSE_MON_STUCK_DET_EN: sticky, set when a
//                     phase counter saturates
//
// Configuration macro: PULSE_MON_STUCK_DET_EN
//   defined     : saturating phase counter sets stuck, FSM re-aligns
//   not defined : saturated counter holds until the next edge
// -----------------------------------------------------------------------------
module pulse_width_monitor #(
  parameter int CNT_W       = 16,
  parameter int EXP_HIGH    = 10,
  parameter int EXP_LOW     = 10,
  parameter int TOL         = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] high_width,
  output logic [CNT_W-1:0] low_width,
  output logic             width_valid,
  output logic             err_high,
  output logic             err_low,
  output logic [CNT_W-1:0] period_cnt,
  output logic             locked
`ifdef PULSE_MON_STUCK_DET_EN
  ,
  output logic             stuck
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_LOW,
    ST_HIGH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Lower tolerance bound clamps at zero.
  localparam int HIGH_LO = (EXP_HIGH > TOL) ? EXP_HIGH - TOL : 0;
  localparam int HIGH_HI = EXP_HIGH + TOL;
  localparam int LOW_LO  = (EXP_LOW > TOL) ? EXP_LOW - TOL : 0;
  localparam int LOW_HI  = EXP_LOW + TOL;

  // A saturated width is never trusted, even if the window would contain it.
  function automatic logic out_of_tol(input logic [CNT_W-1:0] w,
                                      input int lo, input int hi);
    int wi;
    wi = int'(w);
    return (wi < lo) || (wi > hi) || (w == CNT_MAX);
  endfunction

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ps, ps_d;
  logic                   rise, fall;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       low_meas;
  logic                   cnt_sat;
  logic [CNT_W-1:0]       cnt_inc;

  assign ps      = sync_q[SYNC_STAGES-1];
  assign rise    = ps & ~ps_d;
  assign fall    = ~ps & ps_d;
  assign cnt_sat = (cnt == CNT_MAX);
  assign cnt_inc = cnt_sat ? cnt : cnt + CNT_ONE;
  assign locked  = (state_q == ST_LOW) || (state_q == ST_HIGH);

  // Synchroniser and edge-detect history.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      ps_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      ps_d   <= ps;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ALIGN;
        ST_ALIGN: if (fall) state_d = ST_LOW;
        ST_LOW: begin
          if (rise) state_d = ST_HIGH;
`ifdef PULSE_MON_STUCK_DET_EN
          else if (cnt_sat) state_d = ST_ALIGN;
`endif
        end
        ST_HIGH: begin
          if (fall) state_d = ST_LOW;
`ifdef PULSE_MON_STUCK_DET_EN
          else if (cnt_sat) state_d = ST_ALIGN;
`endif
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Phase counter and reported results. The counter is loaded with 1 on the
  // edge cycle so a stored width equals the number of cycles ps held the level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      low_meas    <= '0;
      high_width  <= '0;
      low_width   <= '0;
      width_valid <= 1'b0;
      err_high    <= 1'b0;
      err_low     <= 1'b0;
      period_cnt  <= '0;
`ifdef PULSE_MON_STUCK_DET_EN
      stuck       <= 1'b0;
`endif
    end else begin
      width_valid <= 1'b0;
      if (!enable) begin
        // In-flight period is dropped; results and errors hold.
        cnt <= '0;
      end else begin
        case (state_q)
          ST_ALIGN: cnt <= fall ? CNT_ONE : '0;
          ST_LOW: begin
            if (rise) begin
              low_meas <= cnt;
              cnt      <= CNT_ONE;
            end
`ifdef PULSE_MON_STUCK_DET_EN
            else if (cnt_sat) begin
              stuck <= 1'b1;
              cnt   <= '0;
            end
`endif
            else cnt <= cnt_inc;
          end
          ST_HIGH: begin
            if (fall) begin
              high_width  <= cnt;
              low_width   <= low_meas;
              width_valid <= 1'b1;
              err_high    <= err_high | out_of_tol(cnt, HIGH_LO, HIGH_HI);
              err_low     <= err_low  | out_of_tol(low_meas, LOW_LO, LOW_HI);
              if (period_cnt != CNT_MAX) period_cnt <= period_cnt + CNT_ONE;
              cnt         <= CNT_ONE;
            end
`ifdef PULSE_MON_STUCK_DET_EN
            else if (cnt_sat) begin
              stuck <= 1'b1;
              cnt   <= '0;
            end
`endif
            else cnt <= cnt_inc;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_monitor.sv
// -----------------------------------------------------------------------------
// tb_pulse_width_monitor
//
// Drives pulse trains as lists of phase lengths (first phase high, alternating,
// last phase low), one pulse_in value per clk. The reference model works on
// those lists directly: after the discarded leading high, each (low, high)
// pair that is closed by a following low phase is one reported period.
// CNT_W is 4 so counter and period saturation (15) are reachable.
// -----------------------------------------------------------------------------
module tb_pulse_width_monitor;

  localparam int CNT_W = 4;
  localparam int WMAX  = 15;
  localparam int EXP_H = 10;
  localparam int EXP_L = 10;
  localparam int TOL   = 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             pulse_in;
  logic [CNT_W-1:0] high_width, low_width, period_cnt;
  logic             width_valid, err_high, err_low, locked;
`ifdef PULSE_MON_STUCK_DET_EN
  logic             stuck;
`endif

  pulse_width_monitor #(
    .CNT_W(CNT_W), .EXP_HIGH(EXP_H), .EXP_LOW(EXP_L), .TOL(TOL), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pulse_in(pulse_in),
    .high_width(high_width), .low_width(low_width), .width_valid(width_valid),
    .err_high(err_high), .err_low(err_low), .period_cnt(period_cnt),
    .locked(locked)
`ifdef PULSE_MON_STUCK_DET_EN
    , .stuck(stuck)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // Observed strobes, sampled on the falling edge.
  int obs_hw[$], obs_lw[$], obs_t[$];
  always @(negedge clk) begin
    if (width_valid === 1'b1) begin
      obs_hw.push_back(int'(high_width));
      obs_lw.push_back(int'(low_width));
      obs_t.push_back(cyc);
    end
  end

  // Reference model state.
  int ph[$];
  int exp_hw[$], exp_lw[$];
  bit m_err_h, m_err_l;
  int m_periods, m_hw, m_lw;
  logic [3*CNT_W+2:0] exp_vec, obs_vec;

  function automatic bit in_tol(input int w, input int e);
    int lo;
    lo = (e > TOL) ? e - TOL : 0;
    return (w >= lo) && (w <= e + TOL) && (w < WMAX);
  endfunction

  function automatic int sat(input int w);
    return (w > WMAX) ? WMAX : w;
  endfunction

  task automatic model_reset();
    m_err_h = 0; m_err_l = 0; m_periods = 0; m_hw = 0; m_lw = 0;
  endtask

  task automatic model_train();
    for (int k = 1; k + 2 < ph.size(); k += 2) begin
      m_lw = sat(ph[k]);
      m_hw = sat(ph[k+1]);
      exp_lw.push_back(m_lw);
      exp_hw.push_back(m_hw);
      if (!in_tol(m_hw, EXP_H)) m_err_h = 1;
      if (!in_tol(m_lw, EXP_L)) m_err_l = 1;
      if (m_periods < WMAX) m_periods++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    pulse_in = lvl;
    step(n);
  endtask

  task automatic clear_q();
    obs_hw.delete(); obs_lw.delete(); obs_t.delete();
    exp_hw.delete(); exp_lw.delete();
  endtask

  // Restart from IDLE, then play ph[] with a short low tail so the final
  // falling edge has time to produce its strobe.
  task automatic run_train();
    enable = 1'b0;
    drive(1'b0, 2);
    clear_q();
    enable = 1'b1;
    foreach (ph[i]) drive((i % 2) == 0, ph[i]);
    drive(1'b0, 4);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    drive(1'b0, 2);
    reset_n = 1'b1;
    step(1);
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    drive(1'b0, 3);
    n_checks++;
    if ({high_width, low_width, period_cnt} !== '0)
      $display("FAIL reset_values: got hw=%0d lw=%0d pc=%0d required 0/0/0",
               high_width, low_width, period_cnt);
    else n_pass++;
    n_checks++;
    if ({width_valid, err_high, err_low, locked} !== 4'b0000)
      $display("FAIL reset_flags: got %b required 0000",
               {width_valid, err_high, err_low, locked});
    else n_pass++;
`ifdef PULSE_MON_STUCK_DET_EN
    n_checks++;
    if (stuck !== 1'b0) $display("FAIL reset_stuck: got %b required 0", stuck);
    else n_pass++;
`endif
    reset_n = 1'b1;
    step(1);
    model_reset();
  endtask

  task automatic test_nominal();
    ph = '{6, 10, 10, 10, 10, 10, 10, 10, 10, 6};
    run_train();
    model_train();
    n_checks++;
    if (obs_hw.size() != exp_hw.size())
      $display("FAIL nominal_count: got %0d strobes required %0d", obs_hw.size(), exp_hw.size());
    else n_pass++;
    foreach (exp_hw[i]) if (i < obs_hw.size()) begin
      n_checks++;
      if (obs_hw[i] !== exp_hw[i] || obs_lw[i] !== exp_lw[i])
        $display("FAIL nominal_widths[%0d]: got %0d/%0d required %0d/%0d",
                 i, obs_hw[i], obs_lw[i], exp_hw[i], exp_lw[i]);
      else n_pass++;
    end
    for (int i = 1; i < obs_t.size(); i++) begin
      n_checks++;
      if (obs_t[i] - obs_t[i-1] != EXP_H + EXP_L)
        $display("FAIL nominal_spacing[%0d]: got %0d cycles required %0d",
                 i, obs_t[i] - obs_t[i-1], EXP_H + EXP_L);
      else n_pass++;
    end
    exp_vec = {m_err_h, m_err_l, 1'b1, CNT_W'(m_periods), CNT_W'(m_hw), CNT_W'(m_lw)};
    obs_vec = {err_high, err_low, locked, period_cnt, high_width, low_width};
    n_checks++;
    if (obs_vec !== exp_vec) $display("FAIL nominal_state: got %h required %h", obs_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_tolerance();
    // Exactly at both tolerance edges: no error.
    ph = '{6, 11, 9, 9, 11, 6};
    run_train();
    model_train();
    n_checks++;
    if (obs_hw.size() != exp_hw.size())
      $display("FAIL tol_edge_count: got %0d strobes required %0d", obs_hw.size(), exp_hw.size());
    else n_pass++;
    foreach (exp_hw[i]) if (i < obs_hw.size()) begin
      n_checks++;
      if (obs_hw[i] !== exp_hw[i] || obs_lw[i] !== exp_lw[i])
        $display("FAIL tol_edge_widths[%0d]: got %0d/%0d required %0d/%0d",
                 i, obs_hw[i], obs_lw[i], exp_hw[i], exp_lw[i]);
      else n_pass++;
    end
    n_checks++;
    if ({err_high, err_low} !== {m_err_h, m_err_l})
      $display("FAIL tol_edge_errs: got %b%b required %b%b", err_high, err_low, m_err_h, m_err_l);
    else n_pass++;
    // One cycle outside the window.
    ph = '{6, 10, 8, 6};
    run_train();
    model_train();
    exp_vec = {m_err_h, m_err_l, 1'b1, CNT_W'(m_periods), CNT_W'(m_hw), CNT_W'(m_lw)};
    obs_vec = {err_high, err_low, locked, period_cnt, high_width, low_width};
    n_checks++;
    if (obs_vec !== exp_vec) $display("FAIL tol_out_state: got %h required %h", obs_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_high_long();
    apply_reset();
    ph = '{6, 10, 12, 10, 10, 6};
    run_train();
    model_train();
    n_checks++;
    if (obs_hw.size() != exp_hw.size())
      $display("FAIL high_long_count: got %0d strobes required %0d", obs_hw.size(), exp_hw.size());
    else n_pass++;
    foreach (exp_hw[i]) if (i < obs_hw.size()) begin
      n_checks++;
      if (obs_hw[i] !== exp_hw[i] || obs_lw[i] !== exp_lw[i])
        $display("FAIL high_long_widths[%0d]: got %0d/%0d required %0d/%0d",
                 i, obs_hw[i], obs_lw[i], exp_hw[i], exp_lw[i]);
      else n_pass++;
    end
    exp_vec = {m_err_h, m_err_l, 1'b1, CNT_W'(m_periods), CNT_W'(m_hw), CNT_W'(m_lw)};
    obs_vec = {err_high, err_low, locked, period_cnt, high_width, low_width};
    n_checks++;
    if (obs_vec !== exp_vec) $display("FAIL high_long_state: got %h required %h", obs_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    apply_reset();
    ph = '{6, 10, 10, 10};
    run_train();          // one period reported, now mid-low
    model_train();
    drive(1'b1, 5);       // mid-high when enable drops
    clear_q();
    enable = 1'b0;
    drive(1'b1, 5);
    drive(1'b0, 10);
    drive(1'b1, 10);
    drive(1'b0, 6);
    exp_vec = {m_err_h, m_err_l, 1'b0, CNT_W'(m_periods), CNT_W'(m_hw), CNT_W'(m_lw)};
    obs_vec = {err_high, err_low, locked, period_cnt, high_width, low_width};
    n_checks++;
    if (obs_hw.size() != 0 || obs_vec !== exp_vec)
      $display("FAIL enable_drop_hold: got %0d strobes state %h required 0 strobes state %h",
               obs_hw.size(), obs_vec, exp_vec);
    else n_pass++;
    // Re-enable while high: the first high is a discarded partial phase.
    enable = 1'b1;
    drive(1'b1, 6);
    drive(1'b0, 11);
    drive(1'b1, 9);
    n_checks++;
    if (obs_hw.size() != 0)
      $display("FAIL reenable_early: got %0d strobes required 0", obs_hw.size());
    else n_pass++;
    drive(1'b0, 6);
    ph = '{6, 11, 9, 6};
    model_train();
    n_checks++;
    if (obs_hw.size() != 1 || (obs_hw.size() == 1 && (obs_hw[0] != 9 || obs_lw[0] != 11)))
      $display("FAIL reenable_strobe: got %0d strobes (first %0d/%0d) required 1 strobe 9/11",
               obs_hw.size(), obs_hw.size() ? obs_hw[0] : -1, obs_lw.size() ? obs_lw[0] : -1);
    else n_pass++;
    exp_vec = {m_err_h, m_err_l, 1'b1, CNT_W'(m_periods), CNT_W'(m_hw), CNT_W'(m_lw)};
    obs_vec = {err_high, err_low, locked, period_cnt, high_width, low_width};
    n_checks++;
    if (obs_vec !== exp_vec) $display("FAIL reenable_state: got %h required %h", obs_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_saturation();
    apply_reset();
    ph = '{6, 10, 25, 6};
    run_train();
`ifdef PULSE_MON_STUCK_DET_EN
    // Saturation aborts the period: nothing reported, stuck set.
    n_checks++;
    if (stuck !== 1'b1) $display("FAIL stuck_flag: got %b required 1", stuck);
    else n_pass++;
`else
    model_train();
`endif
    n_checks++;
    if (obs_hw.size() != exp_hw.size())
      $display("FAIL sat_count: got %0d strobes required %0d", obs_hw.size(), exp_hw.size());
    else n_pass++;
    foreach (exp_hw[i]) if (i < obs_hw.size()) begin
      n_checks++;
      if (obs_hw[i] !== exp_hw[i] || obs_lw[i] !== exp_lw[i])
        $display("FAIL sat_widths[%0d]: got %0d/%0d required %0d/%0d",
                 i, obs_hw[i], obs_lw[i], exp_hw[i], exp_lw[i]);
      else n_pass++;
    end
    exp_vec = {m_err_h, m_err_l, 1'b1, CNT_W'(m_periods), CNT_W'(m_hw), CNT_W'(m_lw)};
    obs_vec = {err_high, err_low, locked, period_cnt, high_width, low_width};
    n_checks++;
    if (obs_vec !== exp_vec) $display("FAIL sat_state: got %h required %h", obs_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      ph.delete();
      ph.push_back(6);
      for (int p = 0; p < 8; p++) begin
        ph.push_back(int'($urandom_range(14, 1)));
        ph.push_back(int'($urandom_range(14, 1)));
      end
      ph.push_back(int'($urandom_range(8, 1)));
      run_train();
      model_train();
      n_checks++;
      if (obs_hw.size() != exp_hw.size())
        $display("FAIL random%0d_count: got %0d strobes required %0d", t, obs_hw.size(), exp_hw.size());
      else n_pass++;
      foreach (exp_hw[i]) if (i < obs_hw.size()) begin
        n_checks++;
        if (obs_hw[i] !== exp_hw[i] || obs_lw[i] !== exp_lw[i])
          $display("FAIL random%0d_widths[%0d]: got %0d/%0d required %0d/%0d",
                   t, i, obs_hw[i], obs_lw[i], exp_hw[i], exp_lw[i]);
        else n_pass++;
      end
      exp_vec = {m_err_h, m_err_l, 1'b1, CNT_W'(m_periods), CNT_W'(m_hw), CNT_W'(m_lw)};
      obs_vec = {err_high, err_low, locked, period_cnt, high_width, low_width};
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL random%0d_state: got %h required %h", t, obs_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_low();
    ph = '{6, 10, 12, 10};
    run_train();          // ends mid-low with err_high set
    reset_n = 1'b0;
    step(1);
    n_checks++;
    if ({high_width, low_width, period_cnt, width_valid, err_high, err_low, locked} !== '0)
      $display("FAIL mid_low_reset: got hw=%0d lw=%0d pc=%0d flags=%b required all 0",
               high_width, low_width, period_cnt, {width_valid, err_high, err_low, locked});
    else n_pass++;
    reset_n = 1'b1;
    model_reset();
    ph = '{6, 10, 10, 6};
    run_train();
    model_train();
    n_checks++;
    if (obs_hw.size() != exp_hw.size())
      $display("FAIL post_reset_count: got %0d strobes required %0d", obs_hw.size(), exp_hw.size());
    else n_pass++;
    exp_vec = {m_err_h, m_err_l, 1'b1, CNT_W'(m_periods), CNT_W'(m_hw), CNT_W'(m_lw)};
    obs_vec = {err_high, err_low, locked, period_cnt, high_width, low_width};
    n_checks++;
    if (obs_vec !== exp_vec) $display("FAIL post_reset_state: got %h required %h", obs_vec, exp_vec);
    else n_pass++;
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    pulse_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_tolerance();
    test_high_long();
    test_enable_drop();
    test_saturation();
    test_random();
    test_reset_mid_low();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
